// File: rtl/rv32i_pkg.sv
// RV32I decode constants: opcodes, ALU op encoding, op-type/exception bit indices
// and the field-level decode function shared by the decode register and regfile address path.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_EQ, ALU_NEQ, ALU_GE, ALU_GEU
  } alu_op_t;

  localparam int NUM_OPT    = 11;
  localparam int OPT_LUI    = 0;
  localparam int OPT_AUIPC  = 1;
  localparam int OPT_JAL    = 2;
  localparam int OPT_JALR   = 3;
  localparam int OPT_BRANCH = 4;
  localparam int OPT_LOAD   = 5;
  localparam int OPT_STORE  = 6;
  localparam int OPT_ITYPE  = 7;
  localparam int OPT_RTYPE  = 8;
  localparam int OPT_FENCE  = 9;
  localparam int OPT_SYSTEM = 10;

  localparam int NUM_EXC     = 3;
  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;

  typedef logic [NUM_OPT-1:0] op_type_t;

  typedef struct packed {
    op_type_t           op_type;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic               rd_wr;
    logic [NUM_EXC-1:0] exc;
    alu_op_t            alu_op;
  } dec_t;

  // Shared by OP and OP-IMM; alt selects SUB (register form only) and SRA.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_EQ;
      3'b001:  return ALU_NEQ;
      3'b100:  return ALU_SLT;
      3'b101:  return ALU_GE;
      3'b110:  return ALU_SLTU;
      3'b111:  return ALU_GEU;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic dec_t rv32i_decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill, use1, use2, wr;
    f3 = inst[14:12];
    f7 = inst[31:25];
    d = '0;
    ill = 1'b0; use1 = 1'b0; use2 = 1'b0; wr = 1'b0;
    // Opcodes all end in 2'b11, so a compressed encoding falls into default.
    case (inst[6:0])
      OPC_LUI:     begin d.op_type[OPT_LUI] = 1'b1; wr = 1'b1; end
      OPC_AUIPC:   begin d.op_type[OPT_AUIPC] = 1'b1; wr = 1'b1; end
      OPC_JAL:     begin d.op_type[OPT_JAL] = 1'b1; wr = 1'b1; end
      OPC_JALR:    begin d.op_type[OPT_JALR] = 1'b1; use1 = 1'b1; wr = 1'b1; ill = (f3 != 3'b000); end
      OPC_BRANCH:  begin
        d.op_type[OPT_BRANCH] = 1'b1; use1 = 1'b1; use2 = 1'b1;
        ill = (f3[2:1] == 2'b01);
        d.alu_op = branch_op(f3);
      end
      OPC_LOAD:    begin
        d.op_type[OPT_LOAD] = 1'b1; use1 = 1'b1; wr = 1'b1;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE:   begin d.op_type[OPT_STORE] = 1'b1; use1 = 1'b1; use2 = 1'b1; ill = (f3 >= 3'b011); end
      OPC_OPIMM:   begin
        d.op_type[OPT_ITYPE] = 1'b1; use1 = 1'b1; wr = 1'b1;
        ill = ((f3 == 3'b001) && (f7 != 7'b0)) ||
              ((f3 == 3'b101) && (f7 != 7'b0) && (f7 != 7'b0100000));
        d.alu_op = arith_op(f3, inst[30], 1'b0);
      end
      OPC_OP:      begin
        d.op_type[OPT_RTYPE] = 1'b1; use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
        ill = !((f7 == 7'b0) || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        d.alu_op = arith_op(f3, inst[30], 1'b1);
      end
      OPC_MISCMEM: d.op_type[OPT_FENCE] = 1'b1;
      OPC_SYSTEM:  begin d.op_type[OPT_SYSTEM] = 1'b1; use1 = 1'b1; wr = (f3 != 3'b000); end
      default:     ill = 1'b1;
    endcase
    d.exc[EXC_ILLEGAL] = ill;
    d.exc[EXC_ECALL]   = (inst == 32'h0000_0073);
    d.exc[EXC_EBREAK]  = (inst == 32'h0010_0073);
    // Unused operands read as x0 so forwarding never sees a false dependency.
    d.rs1   = (use1 && !ill) ? inst[19:15] : 5'd0;
    d.rs2   = (use2 && !ill) ? inst[24:20] : 5'd0;
    d.rd_wr = wr && (inst[11:7] != 5'd0) && (d.exc == '0);
    return d;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle; decode sits on the slave side.
interface decode_if;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_clk_en;
  logic        stall_execute;
  logic        flush_execute;
  logic        stall_decode;
  logic        flush_decode;
  logic [4:0]  regs_rs1_rd_addr;
  logic [4:0]  regs_rs2_rd_addr;
  logic        decode_clk_en;
  logic [31:0] decode_pc;
  logic [4:0]  decode_r_rs1;
  logic [4:0]  decode_r_rs2;
  logic [4:0]  decode_rd;
  logic        decode_rd_wr_en;
  logic [31:0] decode_imm;
  logic [2:0]  decode_funct3;
  logic [3:0]  decode_alu_op;
  logic [10:0] decode_op_type;
  logic [2:0]  decode_exception;

  modport master (
    output fetch_inst, fetch_pc, fetch_clk_en, stall_execute, flush_execute,
    input  stall_decode, flush_decode, regs_rs1_rd_addr, regs_rs2_rd_addr,
           decode_clk_en, decode_pc, decode_r_rs1, decode_r_rs2, decode_rd, decode_rd_wr_en,
           decode_imm, decode_funct3, decode_alu_op, decode_op_type, decode_exception
  );

  modport slave (
    input  fetch_inst, fetch_pc, fetch_clk_en, stall_execute, flush_execute,
    output stall_decode, flush_decode, regs_rs1_rd_addr, regs_rs2_rd_addr,
           decode_clk_en, decode_pc, decode_r_rs1, decode_r_rs2, decode_rd, decode_rd_wr_en,
           decode_imm, decode_funct3, decode_alu_op, decode_op_type, decode_exception
  );
endinterface

// File: rtl/decode_imm_gen.sv
// Immediate extraction selected by the decoded op type; everything sign-extends from inst[31].
module decode_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] inst,
  input  op_type_t    op_type,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    if (op_type[OPT_LUI] || op_type[OPT_AUIPC])
      imm = {inst[31:12], 12'b0};
    else if (op_type[OPT_JAL])
      imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (op_type[OPT_BRANCH])
      imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (op_type[OPT_STORE])
      imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    else if (op_type[OPT_JALR] || op_type[OPT_LOAD] || op_type[OPT_ITYPE] ||
             op_type[OPT_FENCE] || op_type[OPT_SYSTEM])
      imm = {{21{inst[31]}}, inst[30:20]};
  end
endmodule

// File: rtl/decode.sv
// RV32I decode stage: pipeline register over the fetched instruction, stall/flush
// handshake toward fetch, and the synchronous register-file read addresses.
module decode
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  typedef struct packed {
    logic               clk_en;
    logic [31:0]        pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               rd_wr_en;
    logic [31:0]        imm;
    logic [2:0]         funct3;
    alu_op_t            alu_op;
    op_type_t           op_type;
    logic [NUM_EXC-1:0] exc;
  } state_t;

  localparam state_t ST_RST = '{clk_en: 1'b0, pc: RESET_PC, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                rd_wr_en: 1'b0, imm: 32'd0, funct3: 3'd0, alu_op: ALU_ADD,
                                op_type: '0, exc: '0};

  dec_t        fetch_dec;
  logic [31:0] fetch_imm;
  logic        stall;
  state_t      st_d, st_q;

  decode_imm_gen u_imm_gen (
    .inst    (bus.fetch_inst),
    .op_type (fetch_dec.op_type),
    .imm     (fetch_imm)
  );

  assign stall = st_q.clk_en && bus.stall_execute && !bus.flush_execute;

  always_comb begin
    fetch_dec = rv32i_decode(bus.fetch_inst);
  end

  always_comb begin
    st_d = st_q;
    if (bus.flush_execute) begin
      st_d.clk_en   = 1'b0;
      st_d.rd_wr_en = 1'b0;
      st_d.exc      = '0;
    end else if (!stall) begin
      // A bubble still loads the fields but must not write or trap.
      st_d.clk_en   = bus.fetch_clk_en;
      st_d.pc       = bus.fetch_pc;
      st_d.rs1      = fetch_dec.rs1;
      st_d.rs2      = fetch_dec.rs2;
      st_d.rd       = bus.fetch_inst[11:7];
      st_d.rd_wr_en = bus.fetch_clk_en && fetch_dec.rd_wr;
      st_d.imm      = fetch_imm;
      st_d.funct3   = bus.fetch_inst[14:12];
      st_d.alu_op   = fetch_dec.alu_op;
      st_d.op_type  = fetch_dec.op_type;
      st_d.exc      = bus.fetch_clk_en ? fetch_dec.exc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_RST;
    else     st_q <= st_d;
  end

  // While held, re-read the held operands so a writeback landing now is picked up.
  assign bus.regs_rs1_rd_addr = stall ? st_q.rs1 : fetch_dec.rs1;
  assign bus.regs_rs2_rd_addr = stall ? st_q.rs2 : fetch_dec.rs2;

  assign bus.stall_decode     = stall;
  assign bus.flush_decode     = bus.flush_execute;
  assign bus.decode_clk_en    = st_q.clk_en;
  assign bus.decode_pc        = st_q.pc;
  assign bus.decode_r_rs1     = st_q.rs1;
  assign bus.decode_r_rs2     = st_q.rs2;
  assign bus.decode_rd        = st_q.rd;
  assign bus.decode_rd_wr_en  = st_q.rd_wr_en;
  assign bus.decode_imm       = st_q.imm;
  assign bus.decode_funct3    = st_q.funct3;
  assign bus.decode_alu_op    = st_q.alu_op;
  assign bus.decode_op_type   = st_q.op_type;
  assign bus.decode_exception = st_q.exc;
endmodule

// File: tb/tb_decode.sv
// Decode stage bench: directed literal cases plus randomized traffic against a
// table-driven reference decoder and a cycle model of the stall/flush register.
module tb_decode;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_if bus();
  decode #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [10:0] opt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  exc;
  } ref_t;

  // Class numbers double as op_type bit positions: LUI=0 ... SYSTEM=10.
  function automatic ref_t ref_dec(input logic [31:0] i);
    ref_t       r;
    int         cls;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    logic [7:0] ok3;
    logic [3:0] arith [8];
    logic [3:0] brc [8];
    arith = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
    brc   = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd2, 4'd12, 4'd3, 4'd13};
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37: cls = 0;  7'h17: cls = 1;  7'h6f: cls = 2;  7'h67: cls = 3;
      7'h63: cls = 4;  7'h03: cls = 5;  7'h23: cls = 6;  7'h13: cls = 7;
      7'h33: cls = 8;  7'h0f: cls = 9;  7'h73: cls = 10;
      default: cls = -1;
    endcase
    case (cls)
      3: ok3 = 8'h01;
      4: ok3 = 8'hF3;
      5: ok3 = 8'h37;
      6: ok3 = 8'h07;
      default: ok3 = 8'hFF;
    endcase
    ill = (cls < 0) || !ok3[f3];
    if (cls == 8) ill = ill || !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
    if (cls == 7) ill = ill || ((f3 == 3'd1) && (f7 != 7'h00)) ||
                              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
    r.exc = {i == 32'h0010_0073, i == 32'h0000_0073, ill};
    r.opt = (cls >= 0) ? (11'd1 << cls) : 11'd0;
    r.rs1 = ((cls inside {3, 4, 5, 6, 7, 8, 10}) && !ill) ? i[19:15] : 5'd0;
    r.rs2 = ((cls inside {4, 6, 8}) && !ill) ? i[24:20] : 5'd0;
    r.wr  = ((cls inside {0, 1, 2, 3, 5, 7, 8}) || ((cls == 10) && (f3 != 3'd0))) &&
            (i[11:7] != 5'd0) && (r.exc == 3'd0);
    case (cls)
      0, 1:             r.imm = {i[31:12], 12'h000};
      2:                r.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      4:                r.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      6:                r.imm = 32'($signed({i[31:25], i[11:7]}));
      3, 5, 7, 9, 10:   r.imm = 32'($signed(i[31:20]));
      default:          r.imm = 32'd0;
    endcase
    case (cls)
      4:       r.alu = brc[f3];
      7:       r.alu = ((f3 == 3'd5) && i[30]) ? 4'd9 : arith[f3];
      8:       r.alu = ((f3 == 3'd0) && i[30]) ? 4'd1 : (((f3 == 3'd5) && i[30]) ? 4'd9 : arith[f3]);
      default: r.alu = 4'd0;
    endcase
    return r;
  endfunction

  // Cycle model of the decode register; m_known=0 means fields are don't-care after a flush.
  logic        m_init = 1'b0, m_known = 1'b0;
  logic        m_v, m_wr;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3, m_exc;
  logic [3:0]  m_alu;
  logic [10:0] m_opt;
  ref_t        m_r;

  always @(posedge clk) begin
    m_r = ref_dec(bus.fetch_inst);
    if (rst) begin
      m_init = 1'b1; m_known = 1'b1; m_v = 1'b0; m_wr = 1'b0; m_pc = RST_PC;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_f3 = 0; m_alu = 0; m_opt = 0; m_exc = 0;
    end else if (bus.flush_execute) begin
      m_v = 1'b0; m_wr = 1'b0; m_known = 1'b0;
    end else if (!(m_v && bus.stall_execute)) begin
      m_known = 1'b1;
      m_v   = bus.fetch_clk_en;
      m_pc  = bus.fetch_pc;
      m_rs1 = m_r.rs1; m_rs2 = m_r.rs2; m_rd = bus.fetch_inst[11:7];
      m_wr  = bus.fetch_clk_en && m_r.wr;
      m_imm = m_r.imm; m_f3 = bus.fetch_inst[14:12]; m_alu = m_r.alu; m_opt = m_r.opt;
      m_exc = bus.fetch_clk_en ? m_r.exc : 3'd0;
    end
  end

  ref_t c_r;
  logic c_stall;
  always @(negedge clk) begin
    if (m_init) begin
      c_r = ref_dec(bus.fetch_inst);
      c_stall = m_v && bus.stall_execute && !bus.flush_execute;
      chk("clk_en", bus.decode_clk_en, m_v);
      chk("rd_wr_en", bus.decode_rd_wr_en, m_wr);
      chk("stall_decode", bus.stall_decode, c_stall);
      chk("flush_decode", bus.flush_decode, bus.flush_execute);
      chk("regs_rs1", bus.regs_rs1_rd_addr, c_stall ? m_rs1 : c_r.rs1);
      chk("regs_rs2", bus.regs_rs2_rd_addr, c_stall ? m_rs2 : c_r.rs2);
      if (m_known) begin
        chk("pc", bus.decode_pc, m_pc);
        chk("rs1", bus.decode_r_rs1, m_rs1);
        chk("rs2", bus.decode_r_rs2, m_rs2);
        chk("rd", bus.decode_rd, m_rd);
        chk("imm", bus.decode_imm, m_imm);
        chk("funct3", bus.decode_funct3, m_f3);
        chk("alu_op", bus.decode_alu_op, m_alu);
        chk("op_type", bus.decode_op_type, m_opt);
        chk("exception", bus.decode_exception, m_exc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc, input logic en);
    bus.fetch_inst = inst; bus.fetch_pc = pc; bus.fetch_clk_en = en;
  endtask

  logic [6:0] opcs [11];
  logic [31:0] x;
  int sel;

  initial begin
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    fetch(32'h0, 32'h0, 1'b0);
    bus.stall_execute = 1'b0; bus.flush_execute = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_clk_en", bus.decode_clk_en, 1'b0);
    chk("rst_pc", bus.decode_pc, RST_PC);

    rst = 1'b0;
    fetch(32'hFFD08293, 32'h100, 1'b1);                       // ADDI x5,x1,-3
    cyc();
    chk("addi_v", bus.decode_clk_en, 1'b1);
    chk("addi_rs1", bus.decode_r_rs1, 5'd1);
    chk("addi_rs2", bus.decode_r_rs2, 5'd0);
    chk("addi_rd", bus.decode_rd, 5'd5);
    chk("addi_imm", bus.decode_imm, 32'hFFFFFFFD);
    chk("addi_alu", bus.decode_alu_op, 4'd0);
    chk("addi_opt", bus.decode_op_type, 11'h080);
    chk("addi_wr", bus.decode_rd_wr_en, 1'b1);
    chk("addi_pc", bus.decode_pc, 32'h100);

    fetch(32'hFE208EE3, 32'h104, 1'b1);                       // BEQ x1,x2,-4
    cyc();
    chk("beq_rs1", bus.decode_r_rs1, 5'd1);
    chk("beq_rs2", bus.decode_r_rs2, 5'd2);
    chk("beq_imm", bus.decode_imm, 32'hFFFFFFFC);
    chk("beq_wr", bus.decode_rd_wr_en, 1'b0);
    chk("beq_opt", bus.decode_op_type, 11'h010);
    chk("beq_alu", bus.decode_alu_op, 4'd10);

    fetch(32'hFFD08293, 32'h108, 1'b1);
    cyc();
    bus.stall_execute = 1'b1;
    fetch(32'h123453B7, 32'h10C, 1'b1);                       // LUI x7,0x12345 waits behind the stall
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_stall", bus.stall_decode, 1'b1);
      chk("hold_regs_rs1", bus.regs_rs1_rd_addr, 5'd1);
      chk("hold_pc", bus.decode_pc, 32'h108);
      chk("hold_rd", bus.decode_rd, 5'd5);
    end
    bus.stall_execute = 1'b0;
    cyc();
    chk("release_pc", bus.decode_pc, 32'h10C);
    chk("release_rd", bus.decode_rd, 5'd7);
    chk("release_imm", bus.decode_imm, 32'h12345000);

    bus.stall_execute = 1'b1; bus.flush_execute = 1'b1;
    #1;
    chk("sf_stall", bus.stall_decode, 1'b0);
    chk("sf_flush", bus.flush_decode, 1'b1);
    cyc();
    chk("sf_v", bus.decode_clk_en, 1'b0);
    chk("sf_wr", bus.decode_rd_wr_en, 1'b0);
    bus.stall_execute = 1'b0; bus.flush_execute = 1'b0;

    fetch(32'h12345037, 32'h200, 1'b1);                       // LUI x0
    cyc();
    chk("luix0_imm", bus.decode_imm, 32'h12345000);
    chk("luix0_rs1", bus.decode_r_rs1, 5'd0);
    chk("luix0_rs2", bus.decode_r_rs2, 5'd0);
    chk("luix0_wr", bus.decode_rd_wr_en, 1'b0);

    fetch(32'h00000000, 32'h204, 1'b1);
    cyc();
    chk("zero_exc", bus.decode_exception, 3'b001);
    chk("zero_wr", bus.decode_rd_wr_en, 1'b0);
    chk("zero_rs1", bus.decode_r_rs1, 5'd0);
    chk("zero_rs2", bus.decode_r_rs2, 5'd0);

    fetch(32'h00000073, 32'h208, 1'b1);
    cyc();
    chk("ecall_exc", bus.decode_exception, 3'b010);

    fetch(32'hFFD08293, 32'h20C, 1'b1);
    cyc();
    bus.stall_execute = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_stall_v", bus.decode_clk_en, 1'b0);
    chk("rst_stall_pc", bus.decode_pc, RST_PC);
    rst = 1'b0; bus.stall_execute = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      x = $urandom;
      sel = $urandom_range(0, 15);
      if (sel < 11) x[6:0] = opcs[sel];
      if ($urandom_range(0, 3) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
      if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
      sel = $urandom_range(0, 39);
      if (sel == 0) x = 32'h0000_0073;
      else if (sel == 1) x = 32'h0010_0073;
      fetch(x, $urandom, $urandom_range(0, 9) < 8);
      bus.stall_execute = $urandom_range(0, 3) == 0;
      bus.flush_execute = $urandom_range(0, 11) == 0;
      rst = $urandom_range(0, 99) == 0;
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
